// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads the combinational instruction memory and queues
// {pc, instr} pairs for decode. Define FETCH_PERF_EN to add fetch/flush counters.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] PC_STEP  = 16'h0001
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_en,
    output logic [15:0]                imem_addr,
    input  logic [15:0]                imem_instr,
    input  logic                       redirect_valid,
    input  logic [15:0]                redirect_pc,
    output logic                       if_valid,
    input  logic                       if_ready,
    output logic [15:0]                if_instr,
    output logic [15:0]                if_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]                perf_fetched,
    output logic [15:0]                perf_flushed
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } status_t;

    logic [15:0]   pc_p0;
    logic [AW-1:0] wr_ptr_p0;
    logic [AW-1:0] rd_ptr_p0;
    logic [CW-1:0] count_p0;
    logic [15:0]   buf_pc_p0    [DEPTH];
    logic [15:0]   buf_instr_p0 [DEPTH];

    status_t status;
    logic    push;
    logic    pop;

    always_comb begin
        status = ST_PARTIAL;
        if (count_p0 == '0)
            status = ST_EMPTY;
        else if (count_p0 == CW'(DEPTH))
            status = ST_FULL;
    end

    // A redirect cycle blocks both handshakes so nothing stale leaks past a flush.
    assign pop  = (status != ST_EMPTY) & if_ready & ~redirect_valid;
    assign push = fetch_en & ~redirect_valid & ((status != ST_FULL) | pop);

    assign imem_addr  = pc_p0;
    assign fifo_count = count_p0;
    assign if_valid   = (status != ST_EMPTY) & ~redirect_valid;
    assign if_pc      = (status != ST_EMPTY) ? buf_pc_p0[rd_ptr_p0]    : 16'h0000;
    assign if_instr   = (status != ST_EMPTY) ? buf_instr_p0[rd_ptr_p0] : 16'h0000;

    // Stage p0: PC and queue control
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_p0     <= RESET_PC;
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else if (redirect_valid) begin
            pc_p0     <= redirect_pc;
            wr_ptr_p0 <= '0;
            rd_ptr_p0 <= '0;
            count_p0  <= '0;
        end else begin
            if (push) begin
                pc_p0     <= pc_p0 + PC_STEP;
                wr_ptr_p0 <= wr_ptr_p0 + AW'(1);
            end
            if (pop)
                rd_ptr_p0 <= rd_ptr_p0 + AW'(1);
            if (push && !pop)
                count_p0 <= count_p0 + CW'(1);
            else if (pop && !push)
                count_p0 <= count_p0 - CW'(1);
        end
    end

    // Stage p0: queue storage, validity tracked solely by count_p0
    always_ff @(posedge clk) begin
        if (push) begin
            buf_pc_p0[wr_ptr_p0]    <= pc_p0;
            buf_instr_p0[wr_ptr_p0] <= imem_instr;
        end
    end

`ifdef FETCH_PERF_EN
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [CW-1:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)
                perf_fetched <= sat_add(perf_fetched, CW'(1));
            if (redirect_valid)
                perf_flushed <= sat_add(perf_flushed, count_p0);
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a vector table covering fetch, backpressure,
// stall, redirect, PC wrap and mid-run reset, plus a hand-written redirect-while-full case.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [15:0] imem_addr;
    logic [15:0] imem_instr;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [2:0]  fifo_count;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .RESET_PC (16'h0000),
        .DEPTH    (4),
        .PC_STEP  (16'h0001)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fifo_count     (fifo_count)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_flushed   (perf_flushed)
`endif
    );

    // Memory model: word at address a holds a+1 (so words 0..3 are 0001..0004).
    assign imem_instr = imem_addr + 16'h0001;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          fe;
        bit          rv;
        bit          rdy;
        logic [15:0] rpc;
        bit          chk;
        bit          ev;
        logic [15:0] epc;
        logic [15:0] ein;
        int          ecnt;
        logic [15:0] eaddr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input bit fe, input bit rv, input bit rdy,
                       input logic [15:0] rpc, input bit chk, input bit ev,
                       input logic [15:0] epc, input logic [15:0] ein,
                       input int ecnt, input logic [15:0] eaddr);
        vec_t v;
        v.rst = r; v.fe = fe; v.rv = rv; v.rdy = rdy; v.rpc = rpc;
        v.chk = chk; v.ev = ev; v.epc = epc; v.ein = ein; v.ecnt = ecnt; v.eaddr = eaddr;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic cmp_all(input int idx, input bit ev, input logic [15:0] epc,
                           input logic [15:0] ein, input int ecnt, input logic [15:0] eaddr);
        cmp("if_valid", idx, {15'd0, if_valid}, {15'd0, ev});
        cmp("if_pc", idx, if_pc, epc);
        cmp("if_instr", idx, if_instr, ein);
        cmp("fifo_count", idx, {13'd0, fifo_count}, 16'(ecnt));
        cmp("imem_addr", idx, imem_addr, eaddr);
    endtask

    initial begin
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000; if_ready = 1'b0;

        //   rst fe rv rdy rpc       chk ev pc        instr     cnt addr
        add(1, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 16'h0001);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0001, 16'h0002, 1, 16'h0002);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0002, 16'h0003, 1, 16'h0003);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0003, 16'h0004, 1, 16'h0004);
        // backpressure until full, then drain with simultaneous refill
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0005, 1, 16'h0005);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0005, 2, 16'h0006);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0005, 3, 16'h0007);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0005, 4, 16'h0008);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'h0005, 4, 16'h0008);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0004, 16'h0005, 4, 16'h0008);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0005, 16'h0006, 4, 16'h0009);
        // fetch_en stall: PC holds, queue drains
        add(0, 0, 0, 1, 16'h0000, 1, 1, 16'h0006, 16'h0007, 4, 16'h000A);
        add(0, 0, 0, 1, 16'h0000, 1, 1, 16'h0007, 16'h0008, 3, 16'h000A);
        add(0, 0, 0, 1, 16'h0000, 1, 1, 16'h0008, 16'h0009, 2, 16'h000A);
        // refill to 3 entries, then redirect to 0040
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0009, 16'h000A, 1, 16'h000A);
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0009, 16'h000A, 2, 16'h000B);
        add(0, 1, 1, 1, 16'h0040, 1, 0, 16'h0009, 16'h000A, 3, 16'h000C);
        add(0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0040);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0040, 16'h0041, 1, 16'h0041);
        // redirect to FFFE, PC wraps
        add(0, 1, 1, 1, 16'hFFFE, 1, 0, 16'h0041, 16'h0042, 1, 16'h0042);
        add(0, 1, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'hFFFE);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'hFFFE, 16'hFFFF, 1, 16'hFFFF);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'hFFFF, 16'h0000, 1, 16'h0000);
        add(0, 1, 0, 1, 16'h0000, 1, 1, 16'h0000, 16'h0001, 1, 16'h0001);
        // build count=2, then reset mid-run
        add(0, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h0002, 1, 16'h0002);
        add(1, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'h0002, 2, 16'h0003);
        add(0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000);
        add(0, 0, 0, 1, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 16'h0000);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            fetch_en       = vecs[i].fe;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            if_ready       = vecs[i].rdy;
            #1;
            if (vecs[i].chk)
                cmp_all(i, vecs[i].ev, vecs[i].epc, vecs[i].ein, vecs[i].ecnt, vecs[i].eaddr);
            @(posedge clk);
        end

        // Redirect held for two cycles while the queue is full.
        @(negedge clk);
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            rst = 1'b0; fetch_en = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 16'h0100; if_ready = 1'b1;
        #1;
        cmp_all(100, 1'b0, 16'h0000, 16'h0001, 4, 16'h0004);
        @(posedge clk);
        @(negedge clk);
        #1;
        cmp_all(101, 1'b0, 16'h0000, 16'h0000, 0, 16'h0100);
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        cmp_all(102, 1'b0, 16'h0000, 16'h0000, 0, 16'h0100);
        @(posedge clk);
        @(negedge clk);
        #1;
        cmp_all(103, 1'b1, 16'h0100, 16'h0101, 1, 16'h0101);
`ifdef FETCH_PERF_EN
        cmp("perf_fetched", 103, perf_fetched, 16'd5);
        cmp("perf_flushed", 103, perf_flushed, 16'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
